// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   - mdcont operation codes (MD_*)
//   - FSM state encoding (state_t: ST_IDLE, ST_CALC, ST_FIX)
//   - ITERS: number of CALC iterations for the default 32-bit width
package muldiv_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MTHI  = 3'b001;
  localparam logic [2:0] MD_MTLO  = 3'b010;
  localparam logic [2:0] MD_MULT  = 3'b100;
  localparam logic [2:0] MD_MULTU = 3'b101;
  localparam logic [2:0] MD_DIV   = 3'b110;
  localparam logic [2:0] MD_DIVU  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int ITERS = 32;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor using a WIDTH+1 bit difference; a non-negative difference yields a
// quotient bit of 1 and replaces the remainder.
// Ports:
//   i_rem     in  WIDTH  partial remainder (always < divisor)
//   i_divisor in  WIDTH  divisor magnitude
//   i_bit     in  1      next dividend bit, MSB first
//   o_rem     out WIDTH  updated partial remainder
//   o_q       out 1      quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // A borrow out of the top bit means the shifted remainder was below the divisor.
  assign o_q     = ~w_diff[WIDTH];
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the HI/LO registers.
// Accepts MULT/MULTU (and DIV/DIVU when MULDIV_DIV_EN is defined) from EX,
// iterates one bit per cycle in CALC, applies signs in FIX and writes HI/LO.
// MTHI/MTLO write HI/LO directly in one cycle while idle.
// Build option: MULDIV_DIV_EN -- when undefined, DIV/DIVU are no-ops and no
// divider logic exists.
// Ports:
//   clk     in  1      rising-edge clock
//   reset   in  1      synchronous active-high reset
//   start   in  1      issue strobe
//   mdcont  in  3      operation code (see muldiv_pkg)
//   a, b    in  WIDTH  operands (a is also the MTHI/MTLO source)
//   hi, lo  out WIDTH  architectural HI/LO
//   busy    out 1      multiply/divide in flight
//   done    out 1      one-cycle pulse after HI/LO written by mult/div
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdcont,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // {upper half, lower half} working register
  logic [WIDTH-1:0]   r_mcand;   // multiplicand or divisor magnitude
  logic               r_sign_a, r_sign_b;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy, r_done;

  logic               w_md_issue, w_mthi, w_mtlo;
  logic               w_signed_op;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_step, w_prod_fix;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;

  // Issue decode: only honoured while idle, so anything issued while busy is dropped.
  always_comb begin
    w_md_issue = 1'b0;
    w_mthi     = 1'b0;
    w_mtlo     = 1'b0;
    if (start && (r_state == ST_IDLE)) begin
      case (mdcont)
        MD_NONE:           ;
        MD_MTHI:           w_mthi = 1'b1;
        MD_MTLO:           w_mtlo = 1'b1;
        MD_MULT, MD_MULTU: w_md_issue = 1'b1;
`ifdef MULDIV_DIV_EN
        MD_DIV, MD_DIVU:   w_md_issue = 1'b1;
`endif
        default:           ;
      endcase
    end
  end

  // MULT (100) and DIV (110) are the signed ops.
  assign w_signed_op = ~mdcont[0];
  assign w_abs_a = (w_signed_op && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (w_signed_op && b[WIDTH-1]) ? -b : b;

  // Shift-add: add multiplicand to the upper half when the current multiplier
  // bit (LSB) is set, then shift the whole accumulator right, carry included.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic               r_is_div, r_b_zero;
  logic [WIDTH-1:0]   r_a_orig;
  logic [WIDTH-1:0]   w_div_rem, w_quo_fix, w_rem_fix;
  logic               w_div_q;
  logic [2*WIDTH-1:0] w_div_next;

  // Divide reuses the accumulator: upper half is the partial remainder, lower
  // half shifts dividend bits out of the top while quotient bits enter below.
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_divisor (r_mcand),
    .i_bit     (r_acc[WIDTH-1]),
    .o_rem     (w_div_rem),
    .o_q       (w_div_q)
  );

  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_q};
  assign w_step     = r_is_div ? w_div_next : w_mul_next;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        // Defined divide-by-zero result instead of a trap.
        w_hi_res = r_a_orig;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_rem_fix;
        w_lo_res = w_quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_orig <= '0;
    end else if (w_md_issue) begin
      r_is_div <= mdcont[1];
      r_b_zero <= (b == '0);
      r_a_orig <= a;
    end
  end
`else
  assign w_step = w_mul_next;

  always_comb begin
    w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_fix[WIDTH-1:0];
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_md_issue) w_state_next = ST_CALC;
      ST_CALC: if (r_cnt == CNT_LAST) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath, counter and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_md_issue) begin
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
            r_mcand  <= w_abs_b;
            r_sign_a <= w_signed_op & a[WIDTH-1];
            r_sign_b <= w_signed_op & b[WIDTH-1];
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end else if (w_mthi) begin
            r_hi <= a;
          end else if (w_mtlo) begin
            r_lo <= a;
          end
        end
        ST_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          r_hi   <= w_hi_res;
          r_lo   <= w_lo_res;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus randomized checks of muldiv_unit against an
// arithmetic reference model. Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

  localparam logic [2:0] OP_NONE = 3'b000, OP_MTHI = 3'b001, OP_MTLO = 3'b010,
                         OP_RSVD = 3'b011, OP_MULT = 3'b100, OP_MULTU = 3'b101,
                         OP_DIV = 3'b110, OP_DIVU = 3'b111;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  mdcont;
  logic [31:0] a_i, b_i, hi, lo;
  logic        busy, done;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;   // model of HI/LO

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mdcont(mdcont),
    .a(a_i), .b(b_i), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (DIV_EN && ((op == OP_DIV) || (op == OP_DIVU)));
  endfunction

  // Reference result for an accepted multiply/divide, from plain arithmetic.
  task automatic model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
    longint p;
    longint unsigned pu;
    int sa, sb;
    h = '0; l = '0;
    case (op)
      OP_MULT: begin
        sa = $signed(a); sb = $signed(b);
        p = longint'(sa) * longint'(sb);
        {h, l} = p;
      end
      OP_MULTU: begin
        pu = longint'({32'b0, a}) * longint'({32'b0, b});
        {h, l} = pu;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (op == OP_DIVU) begin
          l = a / b; h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 0;
        end else begin
          sa = $signed(a); sb = $signed(b);
          l = sa / sb; h = sa % sb;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one op, optionally inject a second start at sample inj_k and/or a
  // reset at sample rst_k (-1 disables), then observe 40 cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_k, input logic [2:0] inj_op, input logic [31:0] inj_a,
                        input int rst_k);
    int bc = 0, dc = 0, da = -1;
    logic [31:0] dh = '0, dl = '0, h0, l0, eh, el;
    bit md = is_md(op);
    @(negedge clk);
    start = 1'b1; mdcont = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    h0 = hi; l0 = lo;
    for (int k = 0; k < 40; k++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (da < 0) begin da = k; dh = hi; dl = lo; end
      end
      if (rst_k >= 0 && k == rst_k + 1) begin
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_hi", {32'b0, hi}, 64'd0);
        check_eq("rst_lo", {32'b0, lo}, 64'd0);
      end
      start = 1'b0; reset = 1'b0;
      if (k == inj_k) begin start = 1'b1; mdcont = inj_op; a_i = inj_a; b_i = '0; end
      if (k == rst_k) reset = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b0;

    if (rst_k >= 0) begin
      m_hi = '0; m_lo = '0;
      check_eq("rst_no_done", 64'(dc), 64'd0);
    end else if (md) begin
      model_md(op, a, b, eh, el);
      m_hi = eh; m_lo = el;
      check_eq("busy_cycles", 64'(bc), 64'd33);
      check_eq("done_cycle", 64'(da), 64'd33);
      check_eq("done_pulses", 64'(dc), 64'd1);
      check_eq("result", {dh, dl}, {eh, el});
    end else begin
      if (op == OP_MTHI) m_hi = a;
      if (op == OP_MTLO) m_lo = a;
      check_eq("mv_busy", 64'(bc), 64'd0);
      check_eq("mv_done", 64'(dc), 64'd0);
      check_eq("mv_latency", {h0, l0}, {m_hi, m_lo});
    end
    check_eq("final_hilo", {hi, lo}, {m_hi, m_lo});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done_at=%0d",
             op, a, b, hi, lo, bc, da);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mdcont = OP_NONE; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("reset_hilo", {hi, lo}, 64'd0);
    check_eq("reset_flags", {62'b0, busy, done}, 64'd0);

    // Ignored MTHI during a multiply, then reset mid-operation.
    run_op(OP_MULT, 32'd5, 32'd5, 5, OP_MTHI, 32'hAAAA_AAAA, -1);
    check_eq("ignored_mthi", {hi, lo}, {32'd0, 32'd25});
    run_op(OP_MULT, 32'd5, 32'd5, -1, OP_NONE, 32'd0, 10);

    // Directed cases.
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        -1, OP_NONE, 0, -1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, OP_NONE, 0, -1);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        -1, OP_NONE, 0, -1);
    run_op(OP_DIVU,  32'd7,         32'd2,        -1, OP_NONE, 0, -1);
    run_op(OP_DIV,   32'h1234_5678, 32'd0,        -1, OP_NONE, 0, -1);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, OP_NONE, 0, -1);
    run_op(OP_RSVD,  32'h5555_5555, 32'd1,        -1, OP_NONE, 0, -1);
    run_op(OP_NONE,  32'h6666_6666, 32'd1,        -1, OP_NONE, 0, -1);

    // Back-to-back MTHI then MTLO.
    @(negedge clk);
    start = 1'b1; mdcont = OP_MTHI; a_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_eq("mthi_hi", {32'b0, hi}, {32'b0, 32'hDEAD_BEEF});
    check_eq("mthi_flags", {62'b0, busy, done}, 64'd0);
    mdcont = OP_MTLO; a_i = 32'h0123_4567;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h0123_4567});
    check_eq("mtlo_flags", {62'b0, busy, done}, 64'd0);
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h0123_4567;
    $display("op=mthi/mtlo hi=%h lo=%h", hi, lo);

    // Randomized sequence of all op codes.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_op(op, rnd_operand(), rnd_operand(), -1, OP_NONE, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
